uart_autobaud_ctrl: RTL and testbench
=====================================

UART_AUTOBAUD_CTRL -- requirements
Module: uart_autobaud_ctrl

Interface
REQ-001 Parameter DEFAULT_BAUD_VAL, default 13'd26, is the baud_val driven after reset.
REQ-002 Parameter CNT_W, default 21, is the width of the measurement counter.
REQ-003 Port clk, input, 1 bit: system clock, the only clock.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: one-cycle arm request, ignored while busy=1.
REQ-006 Port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 Port baud_val, output, 13 bits: divider value for the baud generator.
REQ-008 Port baud_val_fraction, output, 3 bits: fractional divider value in eighths.
REQ-009 Port baud_load, output, 1 bit: one-cycle pulse when new baud_val/baud_val_fraction are valid.
REQ-010 Port busy, output, 1 bit: high from arm until done or err.
REQ-011 Port done, output, 1 bit: sticky success flag, cleared by the next accepted start.
REQ-012 Port err, output, 1 bit: sticky failure flag, cleared by the next accepted start.

Function
REQ-013 rx SHALL pass a 2-FF synchronizer plus an edge register; a falling edge flag rises 3 clk after the rx transition.
REQ-014 States SHALL be IDLE, ARM, MEASURE, CALC, FIN.
- IDLE: start -> ARM.
- ARM: synchronized rx low -> stay; first falling edge -> MEASURE with counter C=1 and edge count E=1.
- MEASURE: C increments every clk; each falling edge increments E; the fifth falling edge (E=5) -> CALC.
- CALC -> FIN -> IDLE.
REQ-015 The measurement character SHALL be 0x55, sent LSB first; falling edges 1 to 5 span exactly 8 bit times.
REQ-016 Quantity Q SHALL equal (C+8)>>4; outputs SHALL be baud_val=(Q>>3)-1 and baud_val_fraction=Q[2:0].
REQ-017 In FIN, baud_val, baud_val_fraction and done SHALL update and baud_load SHALL pulse, 2 clk after the fifth edge flag.
REQ-018 Interval check: I1 is the clk count between edges 1 and 2; each later 2-bit interval outside [I1-(I1>>2), I1+(I1>>2)] SHALL give err.
REQ-019 C reaching all-ones in MEASURE (timeout) SHALL give err.
REQ-020 Q<8 (baud_val would underflow) or (Q>>3)-1 > 8191 SHALL give err.
REQ-021 On err, baud_val and baud_val_fraction SHALL hold their prior values, baud_load SHALL stay 0, and the FSM SHALL return to IDLE.
REQ-022 A start arriving in the same cycle as FIN SHALL be ignored.

Reset
REQ-023 reset SHALL force state IDLE, baud_val=DEFAULT_BAUD_VAL, baud_val_fraction=0, baud_load=0, busy=0, done=0, err=0, C=0, E=0, synchronizer flops=1.
REQ-024 reset asserted mid-MEASURE SHALL abort the measurement with no baud_load pulse.

Configuration
REQ-025 With macro UART_AUTOBAUD_FRACTION_EN defined, REQ-016 SHALL apply as written.
REQ-026 Without UART_AUTOBAUD_FRACTION_EN, baud_val SHALL equal ((C+64)>>7)-1 and baud_val_fraction SHALL be held at 0, and the Q<8 test SHALL become (C+64)>>7 = 0.

Structure
REQ-027 Package uart_autobaud_pkg SHALL hold the state enum, CNT_W_DEF=21, EDGE_TARGET=5 and ROUND_FRAC=8/ROUND_INT=64.
REQ-028 The synchronizer and falling-edge detector SHALL be sub-module uart_autobaud_edge_sync.

Verification
REQ-029 0x55 at 432 clk/bit, macro on -> baud_load pulse, baud_val=26, fraction=0, done=1.
REQ-030 0x55 at 434 clk/bit, macro on -> baud_val=26, fraction=1; same stimulus, macro off -> baud_val=26, fraction=0.
REQ-031 0x55 with the fourth bit stretched to 700 clk at 432 clk/bit -> err=1, no baud_load, baud_val unchanged.
REQ-032 start, then rx held high for 2^21 clk after one falling edge -> err=1 (timeout), busy=0.
REQ-033 0x55 at 8 clk/bit (C=64) -> err=1 (underflow); reset pulsed mid-MEASURE -> all outputs at reset values, baud_val=26.

Source files
------------

// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the UART auto-baud controller.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CALC    = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  localparam int CNT_W_DEF    = 21;
  localparam int EDGE_TARGET  = 5;
  localparam int ROUND_FRAC   = 8;
  localparam int ROUND_INT    = 64;
  localparam int FRAC_SHIFT   = 4;
  localparam int INT_SHIFT    = 7;
  localparam int BAUD_VAL_MAX = 8191;

endpackage

// File: rtl/uart_autobaud_edge_sync.sv
// Two-flop synchronizer for rx followed by a registered falling-edge detector.
// The fall flag is a one-cycle pulse three clocks after the rx transition.
module uart_autobaud_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic fall_q, fall_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fall_d  = prev_q & ~sync2_q;
  end

  // Idle line is high, so the chain resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fall_q  <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times five falling edges of a 0x55 character and derives the divider.
// Define UART_AUTOBAUD_FRACTION_EN to produce the 1/8 fractional divider; otherwise it stays 0.
module uart_autobaud_ctrl
  import uart_autobaud_pkg::*;
#(
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd26,
  parameter int          CNT_W            = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx,
  output logic [12:0] baud_val,
  output logic [2:0]  baud_val_fraction,
  output logic        baud_load,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int XW = (CNT_W + 1 > 14) ? CNT_W + 1 : 14;

  logic fall;

  uart_autobaud_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .fall  (fall)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         edge_q, edge_d;
  logic [CNT_W-1:0]   i1_q, i1_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [12:0]        baud_val_q, baud_val_d;
  logic [2:0]         frac_q, frac_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [2:0]         edge_inc;
  logic [CNT_W-1:0]   ivl;
  logic [CNT_W-1:0]   ivl_lo;
  logic [CNT_W:0]     ivl_hi;
  logic               ivl_out;
  logic [XW-1:0]      qi;
  logic [12:0]        bv_calc;
  logic [2:0]         frac_calc;
  logic               calc_bad;
  logic               abort;

  // Every 2-bit interval must stay within +/-25% of the first one.
  assign edge_inc = edge_q + 3'd1;
  assign ivl      = cnt_q - last_q;
  assign ivl_lo   = i1_q - (i1_q >> 2);
  assign ivl_hi   = {1'b0, i1_q} + {1'b0, (i1_q >> 2)};
  assign ivl_out  = (ivl < ivl_lo) || ({1'b0, ivl} > ivl_hi);

`ifdef UART_AUTOBAUD_FRACTION_EN
  logic [XW-1:0] q;
  always_comb begin
    q         = (XW'(cnt_q) + XW'(ROUND_FRAC)) >> FRAC_SHIFT;
    qi        = q >> 3;
    frac_calc = q[2:0];
  end
`else
  always_comb begin
    qi        = (XW'(cnt_q) + XW'(ROUND_INT)) >> INT_SHIFT;
    frac_calc = 3'd0;
  end
`endif

  assign calc_bad = (qi == '0) || (qi > XW'(BAUD_VAL_MAX + 1));
  assign bv_calc  = 13'(qi - XW'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    i1_d       = i1_q;
    last_d     = last_q;
    baud_val_d = baud_val_q;
    frac_d     = frac_q;
    load_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_ARM: begin
        if (fall) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
          edge_d  = 3'd1;
          last_d  = '0;
        end
      end
      ST_MEASURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) begin
          abort = 1'b1;
        end else if (fall) begin
          edge_d = edge_inc;
          last_d = cnt_q;
          if (edge_q == 3'd1) begin
            i1_d = ivl;
          end else if (ivl_out) begin
            abort = 1'b1;
          end
          // Freeze C at the span between the first and last edge.
          if (!abort && edge_inc == 3'(EDGE_TARGET)) begin
            state_d = ST_CALC;
            cnt_d   = cnt_q;
          end
        end
      end
      ST_CALC: begin
        if (calc_bad) begin
          abort = 1'b1;
        end else begin
          state_d    = ST_FIN;
          baud_val_d = bv_calc;
          frac_d     = frac_calc;
          load_d     = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      i1_q       <= '0;
      last_q     <= '0;
      baud_val_q <= DEFAULT_BAUD_VAL;
      frac_q     <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      i1_q       <= i1_d;
      last_q     <= last_d;
      baud_val_q <= baud_val_d;
      frac_q     <= frac_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign baud_val          = baud_val_q;
  assign baud_val_fraction = frac_q;
  assign baud_load         = load_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Scoreboard bench for uart_autobaud_ctrl: expected outcomes come from an edge-timing model
// of the serial waveform; a monitor pops them on each baud_load pulse or err rise.
module tb_uart_autobaud_ctrl;

  localparam int CNT_W = 13;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx = 1'b1;
  logic [12:0] baud_val;
  logic [2:0]  baud_val_fraction;
  logic        baud_load;
  logic        busy;
  logic        done;
  logic        err;

  uart_autobaud_ctrl #(
    .DEFAULT_BAUD_VAL (13'd26),
    .CNT_W            (CNT_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .rx                (rx),
    .baud_val          (baud_val),
    .baud_val_fraction (baud_val_fraction),
    .baud_load         (baud_load),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int bv;
    int frac;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   model_bv = 26;
  int   model_frac = 0;
  logic err_prev = 1'b0;
  logic load_prev = 1'b0;
  int   lvl55[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: find falling edges of the waveform, then apply the timing and divider rules.
  function automatic exp_t predict(input int lvl[10], input int dur[10]);
    exp_t e;
    int   falls[$];
    int   t;
    int   prev;
    int   i1;
    int   ivl;
    int   c;
    int   qi;
    int   fr;
    bit   bad;
    t = 0; prev = 1; i1 = 0; bad = 0; c = 0; fr = 0;
    for (int i = 0; i < 10; i++) begin
      if (prev == 1 && lvl[i] == 0) falls.push_back(t);
      t += dur[i];
      prev = lvl[i];
    end
    if (falls.size() < 5) begin
      bad = 1;
    end else begin
      for (int k = 1; k < 5; k++) begin
        ivl = falls[k] - falls[k-1];
        if (falls[k] - falls[0] >= CMAX) bad = 1;
        else if (k == 1) i1 = ivl;
        else if (ivl < i1 - i1 / 4 || ivl > i1 + i1 / 4) bad = 1;
      end
      c = falls[4] - falls[0];
    end
`ifdef UART_AUTOBAUD_FRACTION_EN
    begin
      int q;
      q  = (c + 8) / 16;
      qi = q / 8;
      fr = q % 8;
      if (q < 8) bad = 1;
    end
`else
    qi = (c + 64) / 128;
    fr = 0;
    if (qi == 0) bad = 1;
`endif
    if (qi - 1 > 8191) bad = 1;
    e.is_err = bad;
    e.bv     = bad ? model_bv : qi - 1;
    e.frac   = bad ? model_frac : fr;
    return e;
  endfunction

  task automatic send_char(input int lvl[10], input int dur[10]);
    for (int i = 0; i < 10; i++) begin
      rx = (lvl[i] != 0);
      repeat (dur[i]) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic run_txn(input string tag, input int lvl[10], input int dur[10], input bit fin_start);
    exp_t e;
    int   n;
    e = predict(lvl, dur);
    sb.push_back(e);
    if (!e.is_err) begin
      model_bv   = e.bv;
      model_frac = e.frac;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(busy), 1);
    repeat (3) @(negedge clk);
    fork
      send_char(lvl, dur);
      begin
        if (fin_start) begin
          n = 0;
          while (!baud_load && n < 12000) begin
            @(negedge clk);
            n++;
          end
          if (baud_load) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_fin_start_busy"}, int'(busy), 0);
            chk({tag, "_fin_start_done"}, int'(done), 1);
          end else begin
            chk({tag, "_fin_load_seen"}, int'(baud_load), 1);
          end
        end
      end
    join
    n = 0;
    while (sb.size() != 0 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_outcome_timeout"}, sb.size(), 0);
      sb.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (baud_load) begin
          if (sb.size() == 0) begin
            chk("unexpected_baud_load", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("load_expected_ok", int'(e.is_err), 0);
            chk("load_baud_val", int'(baud_val), e.bv);
            chk("load_fraction", int'(baud_val_fraction), e.frac);
            chk("load_done", int'(done), 1);
            chk("load_busy", int'(busy), 0);
            chk("load_err", int'(err), 0);
            chk("load_pulse_width", int'(load_prev), 0);
          end
        end
        if (err && !err_prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_err", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("err_expected", int'(e.is_err), 1);
            chk("err_baud_val_held", int'(baud_val), e.bv);
            chk("err_fraction_held", int'(baud_val_fraction), e.frac);
            chk("err_busy", int'(busy), 0);
            chk("err_no_load", int'(baud_load), 0);
          end
        end
      end
      err_prev  = err;
      load_prev = baud_load;
    end
  end

  initial begin
    logic [7:0] ch;
    int d[10];
    int lvl_to[10];
    int d_to[10];
    int t;
    int idx;
    ch = 8'h55;
    for (int i = 0; i < 10; i++) lvl55[i] = (i == 0) ? 0 : (i == 9) ? 1 : int'(ch[i-1]);

    repeat (3) @(negedge clk);
    chk("rst_baud_val", int'(baud_val), 26);
    chk("rst_fraction", int'(baud_val_fraction), 0);
    chk("rst_load", int'(baud_load), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 10; i++) d[i] = 432;
    run_txn("b432", lvl55, d, 0);
    chk("b432_baud_val", int'(baud_val), 26);
    chk("b432_fraction", int'(baud_val_fraction), 0);

    for (int i = 0; i < 10; i++) d[i] = 434;
    run_txn("b434", lvl55, d, 1);
    chk("b434_baud_val", int'(baud_val), 26);
`ifdef UART_AUTOBAUD_FRACTION_EN
    chk("b434_fraction", int'(baud_val_fraction), 1);
`else
    chk("b434_fraction", int'(baud_val_fraction), 0);
`endif

    for (int i = 0; i < 10; i++) d[i] = 432;
    d[4] = 700;
    run_txn("stretch", lvl55, d, 0);
    chk("stretch_err", int'(err), 1);
    chk("stretch_baud_val", int'(baud_val), 26);

    lvl_to = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    d_to   = '{10, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_txn("timeout", lvl_to, d_to, 0);
    chk("timeout_err", int'(err), 1);
    chk("timeout_busy", int'(busy), 0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b0; repeat (100) @(negedge clk);
    rx = 1'b1; repeat (100) @(negedge clk);
    rx = 1'b0; repeat (100) @(negedge clk);
    rx = 1'b1; repeat (50) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_bv = 26;
    model_frac = 0;
    chk("midrst_baud_val", int'(baud_val), 26);
    chk("midrst_fraction", int'(baud_val_fraction), 0);
    chk("midrst_load", int'(baud_load), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    repeat (300) @(negedge clk);

    for (int i = 0; i < 10; i++) d[i] = 8;
    run_txn("b8", lvl55, d, 0);
    for (int i = 0; i < 10; i++) d[i] = 5;
    run_txn("b5", lvl55, d, 0);

    for (int n = 0; n < 8; n++) begin
      t = int'($urandom_range(400, 40));
      for (int i = 0; i < 10; i++) d[i] = t + int'($urandom_range(t / 8)) - t / 16;
      if ($urandom_range(3) == 0) begin
        idx = int'($urandom_range(8, 1));
        d[idx] = d[idx] + t / 2 + int'($urandom_range(t / 2));
      end
      run_txn("rand", lvl55, d, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL global_watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
